// File: rtl/icmp_echo_responder.sv
// icmp_echo_responder
//   Store-and-forward ICMP Echo responder sitting between the MAC RX byte
//   stream and the TX arbiter. Each frame is buffered while the header is
//   qualified. A frame qualifies when it is IPv4, has IHL=5, carries ICMP
//   Echo Request and is addressed to LOCAL_IP. A qualifying frame is
//   replayed with the following changes:
//     - MAC addresses swapped
//     - IP addresses swapped
//     - ICMP type set to Echo Reply
//     - ICMP checksum patched incrementally
//   Every other frame is counted and discarded.
//
//   Optional feature: define VLAN_EN to accept one 802.1Q tag. The tag is
//   passed through unchanged, every IP/ICMP offset moves by +4 and the
//   minimum frame length becomes 46.
//
// Ports
//   clk, rst         system clock, synchronous active-high reset
//   s_axis_*         RX byte stream (tdata/tvalid/tlast in, tready out)
//   m_axis_*         TX byte stream (tdata/tvalid/tlast out, tready in)
//   ping_detect      one-cycle pulse per accepted echo request
//   ping_count       accepted requests (wraps)
//   drop_count       dropped frames: runt, oversize or non-matching (wraps)
module icmp_echo_responder #(
    parameter int          MAX_FRAME_BYTES = 2048,
    parameter logic [31:0] LOCAL_IP        = 32'hC0A8_010A,
    parameter int          CNT_WIDTH       = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [7:0]           s_axis_tdata,
    input  logic                 s_axis_tvalid,
    input  logic                 s_axis_tlast,
    output logic                 s_axis_tready,
    output logic [7:0]           m_axis_tdata,
    output logic                 m_axis_tvalid,
    output logic                 m_axis_tlast,
    input  logic                 m_axis_tready,
    output logic                 ping_detect,
    output logic [CNT_WIDTH-1:0] ping_count,
    output logic [CNT_WIDTH-1:0] drop_count
);
    localparam int AW = $clog2(MAX_FRAME_BYTES);
`ifdef VLAN_EN
    localparam bit VLAN_ON = 1'b1;
`else
    localparam bit VLAN_ON = 1'b0;
`endif

    typedef enum logic [2:0] {IDLE, RECV, DROP, CSUM, SEND} state_t;
    state_t state_q, state_d;

    logic [7:0]           mem [MAX_FRAME_BYTES];
    logic [AW-1:0]        wr_idx_q;
    logic [AW:0]          len_q;
    logic                 ok_q, vlan_q, tag_hi_q;
    logic [31:0]          src_ip_q;
    logic [15:0]          cks_q, new_cks_q;
    logic [AW:0]          f_idx_q, rd_idx_q;
    logic                 rd_valid_q;
    logic [7:0]           rd_data_q;
    logic [7:0]           m_data_q;
    logic                 m_valid_q, m_last_q;
    logic [CNT_WIDTH-1:0] ping_cnt_q, drop_cnt_q;

    logic                 rx_beat, frame_short, out_ready, fetch_en, wr_en;
    logic [AW-1:0]        rd_addr, wr_addr;
    logic [AW:0]          rx_len;
    int unsigned          rx_rel, tx_idx, tx_rel;
    logic [7:0]           tx_byte;
    logic [16:0]          sum17;

    assign rx_beat     = s_axis_tvalid && s_axis_tready;
    assign rx_len      = {1'b0, wr_idx_q} + (AW+1)'(1);
    assign frame_short = rx_len < (vlan_q ? (AW+1)'(46) : (AW+1)'(42));
    // Offset relative to an untagged frame; the tag is only known from byte 14 on.
    assign rx_rel      = 32'(wr_idx_q) - (vlan_q ? 32'd4 : 32'd0);
    assign sum17       = {1'b0, cks_q} + 17'h0_0800;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (rx_beat && !s_axis_tlast) state_d = RECV;
            RECV: if (rx_beat) begin
                if (s_axis_tlast)
                    state_d = (frame_short || !ok_q) ? IDLE : CSUM;
                else if (wr_idx_q == AW'(MAX_FRAME_BYTES-1))
                    state_d = DROP;
            end
            DROP: if (rx_beat && s_axis_tlast) state_d = IDLE;
            CSUM: state_d = SEND;
            SEND: if (m_valid_q && m_axis_tready && m_last_q) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        s_axis_tready = !rst && (state_q == IDLE || state_q == RECV || state_q == DROP);
        ping_detect   = (state_q == CSUM);
    end

    // ---------------- frame buffer (write port) ----------------
    assign wr_en   = rx_beat && (state_q == IDLE || state_q == RECV);
    assign wr_addr = (state_q == IDLE) ? '0 : wr_idx_q;

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= s_axis_tdata;
    end

    // ---------------- RX parser, capture and counters ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_idx_q   <= '0;
            len_q      <= '0;
            ok_q       <= 1'b0;
            vlan_q     <= 1'b0;
            tag_hi_q   <= 1'b0;
            src_ip_q   <= '0;
            cks_q      <= '0;
            new_cks_q  <= '0;
            ping_cnt_q <= '0;
            drop_cnt_q <= '0;
        end else begin
            if (rx_beat && state_q == IDLE) begin
                wr_idx_q <= AW'(1);
                ok_q     <= 1'b1;
                vlan_q   <= 1'b0;
                tag_hi_q <= 1'b0;
                // A one-beat frame is a runt.
                if (s_axis_tlast) drop_cnt_q <= drop_cnt_q + 1'b1;
            end
            if (rx_beat && state_q == RECV) begin
                wr_idx_q <= wr_idx_q + 1'b1;
                len_q    <= rx_len;
                case (rx_rel)
                    // With a tag, rel 12..13 is reached again at bytes 16..17
                    // and then checks the inner EtherType.
                    32'd12: begin
                        if (VLAN_ON && wr_idx_q == AW'(12) && s_axis_tdata == 8'h81)
                            tag_hi_q <= 1'b1;
                        else if (s_axis_tdata != 8'h08)
                            ok_q <= 1'b0;
                    end
                    32'd13: begin
                        if (s_axis_tdata != 8'h00) ok_q <= 1'b0;
                        if (tag_hi_q && wr_idx_q == AW'(13)) vlan_q <= 1'b1;
                    end
                    32'd14: if (s_axis_tdata != 8'h45) ok_q <= 1'b0;
                    32'd23: if (s_axis_tdata != 8'h01) ok_q <= 1'b0;
                    32'd26: src_ip_q[31:24] <= s_axis_tdata;
                    32'd27: src_ip_q[23:16] <= s_axis_tdata;
                    32'd28: src_ip_q[15:8]  <= s_axis_tdata;
                    32'd29: src_ip_q[7:0]   <= s_axis_tdata;
                    32'd30: if (s_axis_tdata != LOCAL_IP[31:24]) ok_q <= 1'b0;
                    32'd31: if (s_axis_tdata != LOCAL_IP[23:16]) ok_q <= 1'b0;
                    32'd32: if (s_axis_tdata != LOCAL_IP[15:8])  ok_q <= 1'b0;
                    32'd33: if (s_axis_tdata != LOCAL_IP[7:0])   ok_q <= 1'b0;
                    32'd34: if (s_axis_tdata != 8'h08) ok_q <= 1'b0;
                    32'd36: cks_q[15:8] <= s_axis_tdata;
                    32'd37: cks_q[7:0]  <= s_axis_tdata;
                    default: ;
                endcase
                // Any frame long enough to pass ends beyond the last checked
                // byte, so ok_q is already final on the tlast beat.
                if (s_axis_tlast && (frame_short || !ok_q))
                    drop_cnt_q <= drop_cnt_q + 1'b1;
            end
            if (rx_beat && state_q == DROP && s_axis_tlast)
                drop_cnt_q <= drop_cnt_q + 1'b1;
            if (state_q == CSUM) begin
                // Type 8 -> 0 raises the one's-complement checksum by 0x0800.
                new_cks_q  <= sum17[15:0] + {15'd0, sum17[16]};
                ping_cnt_q <= ping_cnt_q + 1'b1;
            end
        end
    end

    // ---------------- TX path ----------------
    // Two stages: a read of the frame buffer, then the output register.
    // The read stage is primed during CSUM, so byte 0 reaches the output
    // register on the first edge in SEND.
    assign out_ready = !m_valid_q || m_axis_tready;
    assign fetch_en  = (state_q == CSUM || state_q == SEND) && (f_idx_q < len_q) &&
                       (!rd_valid_q || out_ready);

    // The MAC swap is done by remapping the read address.
    always_comb begin
        if (f_idx_q < (AW+1)'(6))       rd_addr = f_idx_q[AW-1:0] + AW'(6);
        else if (f_idx_q < (AW+1)'(12)) rd_addr = f_idx_q[AW-1:0] - AW'(6);
        else                            rd_addr = f_idx_q[AW-1:0];
    end

    always_ff @(posedge clk) begin
        if (fetch_en) rd_data_q <= mem[rd_addr];
    end

    // The remaining header substitutions do not need the buffered byte.
    always_comb begin
        tx_idx  = 32'(rd_idx_q);
        tx_rel  = tx_idx - (vlan_q ? 32'd4 : 32'd0);
        tx_byte = rd_data_q;
        if (tx_idx >= 32'd12) begin
            case (tx_rel)
                32'd26: tx_byte = LOCAL_IP[31:24];
                32'd27: tx_byte = LOCAL_IP[23:16];
                32'd28: tx_byte = LOCAL_IP[15:8];
                32'd29: tx_byte = LOCAL_IP[7:0];
                32'd30: tx_byte = src_ip_q[31:24];
                32'd31: tx_byte = src_ip_q[23:16];
                32'd32: tx_byte = src_ip_q[15:8];
                32'd33: tx_byte = src_ip_q[7:0];
                32'd34: tx_byte = 8'h00;
                32'd36: tx_byte = new_cks_q[15:8];
                32'd37: tx_byte = new_cks_q[7:0];
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            f_idx_q    <= '0;
            rd_idx_q   <= '0;
            rd_valid_q <= 1'b0;
            m_valid_q  <= 1'b0;
            m_last_q   <= 1'b0;
            m_data_q   <= '0;
        end else begin
            if (state_q == IDLE || state_q == RECV || state_q == DROP) begin
                f_idx_q    <= '0;
                rd_valid_q <= 1'b0;
            end else if (fetch_en) begin
                rd_idx_q   <= f_idx_q;
                f_idx_q    <= f_idx_q + 1'b1;
                rd_valid_q <= 1'b1;
            end else if (out_ready) begin
                rd_valid_q <= 1'b0;
            end
            // The output register only changes when it is empty or being
            // accepted, so it holds steady while the sink stalls.
            if (out_ready) begin
                m_valid_q <= rd_valid_q;
                m_last_q  <= rd_valid_q && (32'(rd_idx_q) + 32'd1 == 32'(len_q));
                if (rd_valid_q) m_data_q <= tx_byte;
            end
        end
    end

    assign m_axis_tdata  = m_data_q;
    assign m_axis_tvalid = m_valid_q;
    assign m_axis_tlast  = m_last_q;
    assign ping_count    = ping_cnt_q;
    assign drop_count    = drop_cnt_q;

endmodule

// File: tb/tb_icmp_echo_responder.sv
`timescale 1ns/1ps
module tb_icmp_echo_responder;
    localparam logic [31:0] LOCAL_IP = 32'hC0A8_010A;
    localparam logic [31:0] PEER_IP  = 32'hC0A8_0114;
    localparam logic [47:0] DST_MAC  = 48'h000A_3500_0001;
    localparam logic [47:0] SRC_MAC  = 48'h0211_2233_4455;

    typedef logic [7:0] bq_t [$];

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  s_axis_tdata;
    logic        s_axis_tvalid, s_axis_tlast, s_axis_tready;
    logic [7:0]  m_axis_tdata;
    logic        m_axis_tvalid, m_axis_tlast, m_axis_tready;
    logic        ping_detect;
    logic [15:0] ping_count, drop_count;

    always #5 clk = ~clk;

    icmp_echo_responder #(
        .MAX_FRAME_BYTES(2048),
        .LOCAL_IP       (LOCAL_IP),
        .CNT_WIDTH      (16)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .s_axis_tdata (s_axis_tdata),
        .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tlast (s_axis_tlast),
        .s_axis_tready(s_axis_tready),
        .m_axis_tdata (m_axis_tdata),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tlast (m_axis_tlast),
        .m_axis_tready(m_axis_tready),
        .ping_detect  (ping_detect),
        .ping_count   (ping_count),
        .drop_count   (drop_count)
    );

    int         n_cmp = 0;
    int         n_bad = 0;
    logic [8:0] exp_q [$];
    logic [7:0] got_q [$];
    int         pulses = 0;
    int         exp_pulses = 0;
    int         exp_ping = 0;
    int         exp_drop = 0;
    bit         rand_ready = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic bq_t make_req(input int len, input logic [31:0] dst,
                                     input logic [15:0] cks, input logic [15:0] etype);
        bq_t f;
        for (int i = 0; i < len; i++) f.push_back(8'((i * 37 + 11) & 255));
        if (len >= 38) begin
            for (int k = 0; k < 6; k++) begin
                f[k]     = 8'(DST_MAC >> (40 - 8 * k));
                f[6 + k] = 8'(SRC_MAC >> (40 - 8 * k));
            end
            f[12] = etype[15:8];
            f[13] = etype[7:0];
            f[14] = 8'h45;
            f[15] = 8'h00;
            f[16] = 8'((len - 14) >> 8);
            f[17] = 8'(len - 14);
            f[22] = 8'h40;
            f[23] = 8'h01;
            for (int k = 0; k < 4; k++) begin
                f[26 + k] = 8'(PEER_IP >> (24 - 8 * k));
                f[30 + k] = 8'(dst >> (24 - 8 * k));
            end
            f[34] = 8'h08;
            f[35] = 8'h00;
            f[36] = cks[15:8];
            f[37] = cks[7:0];
        end
        return f;
    endfunction

    // Echo reply: swap MACs and IPs, type 0, checksum + 0x0800 in one's complement.
    function automatic bq_t mk_reply(input bq_t f);
        bq_t r;
        int  c;
        r = f;
        for (int k = 0; k < 6; k++) begin
            r[k]     = f[k + 6];
            r[k + 6] = f[k];
        end
        for (int k = 0; k < 4; k++) begin
            r[26 + k] = 8'(LOCAL_IP >> (24 - 8 * k));
            r[30 + k] = f[26 + k];
        end
        r[34] = 8'h00;
        c = int'({f[36], f[37]}) + 'h0800;
        if (c > 'hFFFF) c = c - 'h10000 + 1;
        r[36] = 8'(c >> 8);
        r[37] = 8'(c);
        return r;
    endfunction

    task automatic expect_frame(input bq_t r);
        for (int i = 0; i < r.size(); i++) exp_q.push_back({i == r.size() - 1, r[i]});
        exp_ping++;
        exp_pulses++;
    endtask

    // ---------------- compare process ----------------
    logic       hold_prev = 1'b0;
    logic [8:0] prev_beat = '0;
    logic [8:0] exp_beat;
    always @(negedge clk) begin
        if (ping_detect) pulses++;
        if (m_axis_tvalid && hold_prev)
            chk("stall_hold", {23'd0, m_axis_tlast, m_axis_tdata}, {23'd0, prev_beat});
        if (m_axis_tvalid && m_axis_tready) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_tx: got byte 0x%0h, expected no output", m_axis_tdata);
            end else begin
                exp_beat = exp_q.pop_front();
                chk("tx_beat", {23'd0, m_axis_tlast, m_axis_tdata}, {23'd0, exp_beat});
                got_q.push_back(m_axis_tdata);
            end
        end
        hold_prev = m_axis_tvalid && !m_axis_tready;
        prev_beat = {m_axis_tlast, m_axis_tdata};
    end

    // ---------------- sink ready driver ----------------
    initial begin
        m_axis_tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            m_axis_tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic send_frame(input bq_t f, input int abort_at, output int stalls);
        logic acc;
        stalls = 0;
        for (int i = 0; i < f.size(); i++) begin
            if (i == abort_at) break;
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = f[i];
            s_axis_tlast  = (i == f.size() - 1);
            do begin
                @(negedge clk);
                acc = s_axis_tready;
                if (!acc) stalls++;
                @(posedge clk);
                #1;
            end while (!acc && stalls < 5000);
            if (!acc) begin
                n_cmp++;
                n_bad++;
                $display("FAIL rx_accept_timeout: byte %0d not accepted", i);
                break;
            end
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        $display("rx frame: %0d bytes offered, %0d stall cycles", f.size(), stalls);
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((exp_q.size() != 0 || m_axis_tvalid) && n < 10000) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 10000) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain_timeout: %0d beats still expected, 0 required", exp_q.size());
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst           = 1'b1;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst      = 1'b0;
        exp_ping = 0;
        exp_drop = 0;
    endtask

    task automatic check_counts(input string tag);
        chk({tag, "_ping_count"}, 32'(ping_count), exp_ping);
        chk({tag, "_drop_count"}, 32'(drop_count), exp_drop);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        bq_t f, r;
        int  st, cnt;
        rst           = 1'b1;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        s_axis_tdata  = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_tvalid",   32'(m_axis_tvalid), 0);
        chk("rst_tlast",    32'(m_axis_tlast),  0);
        chk("rst_tdata",    32'(m_axis_tdata),  0);
        chk("rst_ping_det", 32'(ping_detect),   0);
        chk("rst_ping_cnt", 32'(ping_count),    0);
        chk("rst_drop_cnt", 32'(drop_count),    0);
        chk("rst_s_tready", 32'(s_axis_tready), 1);
        @(posedge clk);
        #1;

        // 1: basic echo, checksum 0x4D5A -> 0x555A, latency
        f = make_req(74, LOCAL_IP, 16'h4D5A, 16'h0800);
        expect_frame(mk_reply(f));
        got_q.delete();
        send_frame(f, -1, st);
        cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
            if (cnt == 1) chk("ping_detect_in_csum", 32'(ping_detect), 1);
        end while (!m_axis_tvalid && cnt < 10);
        chk("first_tx_latency", cnt, 3);
        wait_drain();
        chk("t1_len",    got_q.size(), 74);
        chk("t1_dmac0",  32'(got_q[0]),  32'h02);
        chk("t1_smac5",  32'(got_q[11]), 32'h01);
        chk("t1_sip0",   32'(got_q[26]), 32'hC0);
        chk("t1_dip3",   32'(got_q[33]), 32'h14);
        chk("t1_type",   32'(got_q[34]), 32'h00);
        chk("t1_cks_hi", 32'(got_q[36]), 32'h55);
        chk("t1_cks_lo", 32'(got_q[37]), 32'h5A);
        chk("t1_ping_literal", 32'(ping_count), 1);
        check_counts("t1");

        // 2: end-around carry, 0xF800 -> 0x0001
        f = make_req(64, LOCAL_IP, 16'hF800, 16'h0800);
        expect_frame(mk_reply(f));
        got_q.delete();
        send_frame(f, -1, st);
        wait_drain();
        chk("t2_cks_hi", 32'(got_q[36]), 32'h00);
        chk("t2_cks_lo", 32'(got_q[37]), 32'h01);
        check_counts("t2");

        // 3: wrong IP and ARP are dropped
        do_reset();
        send_frame(make_req(74, LOCAL_IP + 32'd1, 16'h4D5A, 16'h0800), -1, st);
        exp_drop++;
        send_frame(make_req(60, LOCAL_IP, 16'h0000, 16'h0806), -1, st);
        exp_drop++;
        wait_drain();
        chk("t3_drop_literal", 32'(drop_count), 2);
        chk("t3_ping_literal", 32'(ping_count), 0);
        check_counts("t3");

        // 3b: runt, 41-byte short frame, then the 42-byte minimum
        f.delete();
        f.push_back(8'hAA);
        send_frame(f, -1, st);
        exp_drop++;
        send_frame(make_req(41, LOCAL_IP, 16'h1111, 16'h0800), -1, st);
        exp_drop++;
        f = make_req(42, LOCAL_IP, 16'h2222, 16'h0800);
        expect_frame(mk_reply(f));
        got_q.delete();
        send_frame(f, -1, st);
        wait_drain();
        chk("t3b_len", got_q.size(), 42);
        check_counts("t3b");

        // 4: oversize frame then a valid ping
        send_frame(make_req(2100, LOCAL_IP, 16'h3333, 16'h0800), -1, st);
        exp_drop++;
        chk("t4_oversize_stalls", st, 0);
        f = make_req(74, LOCAL_IP, 16'h4D5A, 16'h0800);
        expect_frame(mk_reply(f));
        send_frame(f, -1, st);
        wait_drain();
        check_counts("t4");

        // 5: random sink stalls, second request held during SEND
        rand_ready = 1'b1;
        f = make_req(74, LOCAL_IP, 16'h1234, 16'h0800);
        expect_frame(mk_reply(f));
        send_frame(f, -1, st);
        cnt = 0;
        while (!m_axis_tvalid && cnt < 20) begin
            @(posedge clk);
            #1;
            cnt++;
        end
        f = make_req(60, LOCAL_IP, 16'hABCD, 16'h0800);
        expect_frame(mk_reply(f));
        send_frame(f, -1, st);
        chk("t5_second_held", 32'(st != 0), 1);
        wait_drain();
        rand_ready = 1'b0;
        check_counts("t5");

        // 6: reset mid-frame, then a fresh request
        send_frame(make_req(74, LOCAL_IP, 16'h4D5A, 16'h0800), 20, st);
        do_reset();
        repeat (10) @(posedge clk);
        #1;
        chk("t6_ping_literal", 32'(ping_count), 0);
        chk("t6_drop_literal", 32'(drop_count), 0);
        f = make_req(74, LOCAL_IP, 16'h4D5A, 16'h0800);
        expect_frame(mk_reply(f));
        send_frame(f, -1, st);
        wait_drain();
        check_counts("t6");

        chk("ping_detect_pulses", pulses, exp_pulses);
        chk("leftover_expected", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, %0d beats still expected", exp_q.size());
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/icmp_echo_responder.md
Name: icmp_echo_responder

Overview:
- Parametrised store-and-forward ICMP Echo responder between the MAC RX byte stream and the TX arbiter.
- Buffers each frame and qualifies it: IPv4, IHL=5, ICMP, Echo Request, destination IP equal to LOCAL_IP, length within bounds.
- Qualifying frames are replayed with MAC and IP addresses swapped and the ICMP type/checksum rewritten. All other frames are discarded.
- Over the previous echo engine it adds: IP filtering, oversize/runt protection, a fully AXI-compliant output handshake, end-around-carry checksum, and statistics counters.

Parameters:
- MAX_FRAME_BYTES, 2048: frame buffer depth in bytes; must be a power of two, minimum 64.
- LOCAL_IP, 32'hC0A8_010A: IPv4 address this block answers for.
- CNT_WIDTH, 16: width of the statistics counters.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- s_axis_tdata  in  8  RX byte
- s_axis_tvalid  in  1  RX valid
- s_axis_tlast  in  1  RX last byte of frame
- s_axis_tready  out  1  RX ready
- m_axis_tdata  out  8  TX byte
- m_axis_tvalid  out  1  TX valid
- m_axis_tlast  out  1  TX last byte
- m_axis_tready  in  1  TX ready
- ping_detect  out  1  one-cycle pulse per accepted request
- ping_count  out  CNT_WIDTH  accepted requests; wraps
- drop_count  out  CNT_WIDTH  dropped frames (oversize, runt, or non-matching); wraps

Behaviour:
- Reset values: state=IDLE, m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, ping_detect=0, both counters=0, s_axis_tready=1 the cycle after rst deasserts.
- A reset mid-frame abandons the frame. No partial output is produced, and the counters are cleared.
- States: IDLE, RECV, DROP, CSUM, SEND.
  - IDLE: s_axis_tready=1. An accepted beat is written to buffer[0] and the block moves to RECV. A single-beat frame (tlast in IDLE) is a runt: drop_count+1, stay IDLE.
  - RECV: s_axis_tready=1. Byte n is stored at buffer[n]. The parser checks the byte at each offset n:
    - 12..13 = 0x0800
    - 14 = 0x45
    - 23 = 0x01
    - 30..33 = LOCAL_IP
    - 34 = 0x08
  - RECV, capture: source IP (bytes 26..29) and checksum (bytes 36..37).
  - RECV, on the tlast beat with length L = n+1:
    - If L<42 or any check failed: drop_count+1, go to IDLE.
    - Otherwise go to CSUM.
  - RECV, overflow: if n reaches MAX_FRAME_BYTES-1 without tlast, go to DROP.
  - DROP: s_axis_tready=1. Discard beats until tlast, then drop_count+1 and go to IDLE. Exactly one increment per frame.
  - CSUM: one cycle. Compute sum17 = checksum + 16'h0800 and new = sum17[15:0] + sum17[16] (16-bit result, end-around carry). Pulse ping_detect, ping_count+1, go to SEND with index 0.
  - SEND: s_axis_tready=0. Output bytes 0..L-1 with these substitutions:
    - 0..5 ← buffer[6..11]
    - 6..11 ← buffer[0..5]
    - 26..29 ← LOCAL_IP, MSB first
    - 30..33 ← captured source IP
    - 34 ← 0x00
    - 36..37 ← new checksum, MSB first
    - all other bytes ← buffer[i]
  - SEND, last byte: m_axis_tlast=1 only on byte L-1. After that beat is accepted, drop tvalid and go to IDLE.
- Output handshake:
  - tvalid, tdata and tlast hold stable while tvalid=1 and tready=0.
  - The index advances only on tvalid&&tready.
  - tvalid does not depend combinationally on tready.
  - Full throughput of 1 byte/cycle under continuous tready.
- Latency: first TX byte is valid on the 3rd cycle after the RX tlast beat is accepted (RECV→CSUM→SEND, registered output).
- Frames arriving during CSUM/SEND are back-pressured (tready=0) and are never lost.
- Ethernet FCS is not present on either interface; the MAC adds and strips it.

Optional Feature:
- VLAN_EN: when defined, a single 802.1Q tag is accepted.
  - If bytes 12..13 = 0x8100, all IP/ICMP offsets shift by +4, the minimum length becomes 46, and the tag is passed through unchanged.
  - Without VLAN_EN, 0x8100 frames fail the EtherType check and are dropped (drop_count+1).

Test Plan:
- 74-byte echo request to 192.168.1.10 from 192.168.1.20, checksum 0x4D5A, tready=1 → 74-byte reply with MACs swapped, IPs swapped, type 0x00, checksum 0x555A, tlast on byte 73; ping_count=1 and a single ping_detect pulse.
- Request with checksum 0xF800 → reply checksum 0x0001 (end-around carry exercised).
- Request to 192.168.1.11, then an ARP frame (EtherType 0x0806) → no TX output; drop_count=2, ping_count=0.
- 2100-byte frame with MAX_FRAME_BYTES=2048 followed by a valid ping → drop_count=1 and a correct reply to the second frame; s_axis_tready stays 1 throughout the oversize frame.
- Valid request with m_axis_tready toggling 1-0-0-1 randomly → byte sequence identical to the tready=1 case, with data stable while stalled; a second request sent during SEND is held (s_axis_tready=0) and then answered.
- rst asserted at byte 20 of a request, then a fresh request → no output for the first frame, counters 0, and a correct reply to the second.
